// File: rtl/fpu_pipe_pkg.sv
// fpu_pipe_pkg: shared constants and helpers for the FPU elastic pipeline blocks
package fpu_pipe_pkg;
  localparam int MAX_STAGES = 8;
  function automatic int cnt_w(input int stages, input int skid);
    return $clog2(stages + skid + 1);
  endfunction
endpackage

// File: rtl/elastic_reg_pipe_if.sv
// elastic_reg_pipe_if: upstream/downstream handshake, flush and status bundle of the elastic pipe
interface elastic_reg_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CW = 2
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0] count;
  logic busy;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, count, busy
  );
  modport slave (
    input flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, busy
  );
endinterface

// File: rtl/elastic_reg_pipe_skid_buffer.sv
// skid_buffer: 1-entry input buffer whose ready depends only on its own state and flush
module skid_buffer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic in_valid,
  output logic in_ready,
  input logic [WIDTH-1:0] in_data,
  output logic out_valid,
  input logic out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic sv;
  logic [WIDTH-1:0] sd;
  assign in_ready = !flush && !sv;
  // a held entry is older than anything on the input, so it always goes first
  assign out_valid = sv || (in_valid && !flush);
  assign out_data = sv ? sd : in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sv <= 1'b0;
      sd <= RESET_VAL;
    end else begin
      sv <= !flush && (sv ? !out_ready : in_valid && !out_ready);
      if (!sv && in_valid && !out_ready) sd <= in_data;
    end
endmodule

// File: rtl/elastic_reg_pipe.sv
// elastic_reg_pipe: valid/ready register pipeline with bubble collapsing, optional input skid,
// synchronous flush and occupancy count
module elastic_reg_pipe
  import fpu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  parameter int SKID = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  elastic_reg_pipe_if.slave bus
);
  localparam int CW = cnt_w(STAGES, SKID);
  logic [STAGES-1:0] v, acc, go, ld;
  logic [WIDTH-1:0] d [STAGES];
  logic [WIDTH-1:0] src [STAGES];
  logic s_v, in_rdy, in_xfer, out_xfer;
  logic [WIDTH-1:0] s_d;
  logic [CW-1:0] cnt;
  if (WIDTH < 1 || STAGES < 1 || STAGES > MAX_STAGES || SKID < 0 || SKID > 1) begin : g_bad_param
    $error("elastic_reg_pipe: illegal parameter set");
  end
  // acc[i]: stage i can take a word, i.e. some stage at or after it is empty or the output drains
  always_comb begin
    logic a;
    a = bus.out_ready;
    go = '0;
    acc = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      go[i] = v[i] && a;
      a = a || !v[i];
      acc[i] = a;
    end
  end
  if (SKID == 1) begin : g_skid
    skid_buffer #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk(clk),
      .rst_n(rst_n),
      .flush(bus.flush),
      .in_valid(bus.in_valid),
      .in_ready(in_rdy),
      .in_data(bus.in_data),
      .out_valid(s_v),
      .out_ready(acc[0]),
      .out_data(s_d)
    );
  end else begin : g_noskid
    assign in_rdy = !bus.flush && acc[0];
    assign s_v = bus.in_valid && !bus.flush;
    assign s_d = bus.in_data;
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic sv;
    logic [WIDTH-1:0] sd;
    if (i == 0) begin : g_head
      assign ld[i] = s_v && acc[i];
      assign src[i] = s_d;
    end else begin : g_body
      assign ld[i] = go[i-1];
      assign src[i] = d[i-1];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sv <= 1'b0;
        sd <= RESET_VAL;
      end else begin
        sv <= !bus.flush && (ld[i] || (sv && !go[i]));
        if (ld[i]) sd <= src[i];
      end
    assign v[i] = sv;
    assign d[i] = sd;
  end
  assign in_xfer = bus.in_valid && in_rdy;
  assign out_xfer = v[STAGES-1] && bus.out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (bus.flush) cnt <= '0;
    else if (in_xfer != out_xfer) cnt <= in_xfer ? cnt + CW'(1) : cnt - CW'(1);
  assign bus.in_ready = in_rdy;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data = d[STAGES-1];
  assign bus.count = cnt;
  assign bus.busy = |cnt;
endmodule
